dev_uart_tx_arb: RTL

//  Round-robin arbiter/sequencer sharing one dev_uart_tx between N byte-stream clients.

---
 rtl/dev_uart_tx_arb_if.sv | 28 ++
 rtl/dev_uart_tx_arb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dev_uart_tx_arb_if.sv
// Bundle of client byte-stream signals and the dev_uart_tx strobe/ack handshake.
// The slave view belongs to the arbiter; the master view belongs to the clients and the UART.
interface dev_uart_tx_arb_if #(
  parameter int N  = 4,
  parameter int IW = 2
);
  logic [N-1:0]   CLI_REQ;
  logic [8*N-1:0] CLI_DATA;
  logic [N-1:0]   CLI_LAST;
  logic [N-1:0]   CLI_TAKEN;
  logic [IW-1:0]  OWNER;
  logic           BUSY;
  logic           ERR;
  logic           TX_STB;
  logic [7:0]     TX_DATA;
  logic           TX_ACK;
  logic           TX_RDY;

  modport slave (
    input  CLI_REQ, CLI_DATA, CLI_LAST, TX_ACK, TX_RDY,
    output CLI_TAKEN, OWNER, BUSY, ERR, TX_STB, TX_DATA
  );

  modport master (
    output CLI_REQ, CLI_DATA, CLI_LAST, TX_ACK, TX_RDY,
    input  CLI_TAKEN, OWNER, BUSY, ERR, TX_STB, TX_DATA
  );
endinterface

// File: rtl/dev_uart_tx_arb.sv
// Round-robin arbiter sharing one dev_uart_tx between N byte-stream clients.
// Holds the grant across multi-byte packets and aborts stalled bytes with a TIC watchdog.
module dev_uart_tx_arb #(
  parameter int N         = 4,
  parameter int IW        = 2,
  parameter int TOUT_TICS = 16,
  parameter int HOLD_TICS = 32
) (
  input logic               CLK,
  input logic               RST_N,
  input logic               TIC,
  dev_uart_tx_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, SHIFT, HOLD} state_t;

  localparam logic [7:0] TOUT_LIM = 8'(TOUT_TICS);
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_TICS);

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          stb_q, stb_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic [N-1:0]  taken_q, taken_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ack_q;

  logic          ack_rise, ack_fall;
  logic [7:0]    cnt_inc;
  logic          pick_found;
  logic [IW-1:0] pick_idx, cand;
  logic          grant_en, rel;
  logic [IW-1:0] grant_idx;

  assign ack_rise = bus.TX_ACK & ~ack_q;
  assign ack_fall = ~bus.TX_ACK & ack_q;
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // First requester at or after the round-robin pointer, wrapping modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!pick_found && bus.CLI_REQ[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      stb_q   <= 1'b0;
      data_q  <= 8'hFF;
      last_q  <= 1'b0;
      taken_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      last_q  <= last_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
      ack_q   <= bus.TX_ACK;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    stb_d     = stb_q;
    data_d    = data_q;
    last_d    = last_q;
    taken_d   = '0;
    cnt_d     = cnt_q;
    grant_en  = 1'b0;
    grant_idx = '0;
    rel       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.TX_RDY && pick_found && !bus.TX_ACK) begin
          grant_en  = 1'b1;
          grant_idx = pick_idx;
        end
      end
      // An ACK rise wins over a TIC arriving in the same cycle.
      SEND: begin
        if (ack_rise) begin
          stb_d   = 1'b0;
          state_d = SHIFT;
          cnt_d   = '0;
        end else if (TIC) begin
          if (cnt_inc >= TOUT_LIM) begin
            stb_d = 1'b0;
            err_d = 1'b1;
            rel   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      SHIFT: begin
        if (ack_fall) begin
          if (last_q) begin
            rel = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
      end
      HOLD: begin
        if (bus.CLI_REQ[owner_q] && !bus.TX_ACK) begin
          grant_en  = 1'b1;
          grant_idx = owner_q;
        end else if (TIC) begin
          if (cnt_inc >= HOLD_LIM) begin
            rel = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_en) begin
      owner_d            = grant_idx;
      busy_d             = 1'b1;
      data_d             = bus.CLI_DATA[{grant_idx, 3'b000} +: 8];
      last_d             = bus.CLI_LAST[grant_idx];
      taken_d[grant_idx] = 1'b1;
      stb_d              = 1'b1;
      state_d            = SEND;
      cnt_d              = '0;
    end

    // OWNER keeps its value after release; only the pointer moves on.
    if (rel) begin
      busy_d  = 1'b0;
      ptr_d   = IW'((int'(owner_q) + 1) % N);
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign bus.CLI_TAKEN = taken_q;
  assign bus.OWNER     = owner_q;
  assign bus.BUSY      = busy_q;
  assign bus.ERR       = err_q;
  assign bus.TX_STB    = stb_q;
  assign bus.TX_DATA   = data_q;

endmodule
